// File: rtl/dcache_sa_if.sv
// CPU request/response and line-refill memory bus for dcache_sa.
// master: CPU plus memory side; slave: the cache.
interface dcache_sa_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned LINE_WORDS = 4
);
  logic                       req_valid;
  logic                       req_ready;
  logic [XLEN-1:0]            req_addr;
  logic                       req_we;
  logic [2:0]                 req_size;
  logic [XLEN-1:0]            req_wdata;
  logic                       resp_valid;
  logic [XLEN-1:0]            resp_rdata;
  logic                       mem_req;
  logic                       mem_we;
  logic [XLEN-1:0]            mem_addr;
  logic [LINE_WORDS*XLEN-1:0] mem_wdata;
  logic                       mem_ack;
  logic [LINE_WORDS*XLEN-1:0] mem_rdata;

  modport master (
    output req_valid, req_addr, req_we, req_size, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_sa.sv
// Set-associative write-back, write-allocate data cache with round-robin replacement.
// Define DCACHE_STATS_EN to build the saturating hit/miss counters.
module dcache_sa #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  dcache_sa_if.slave  bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int unsigned LINE_BITS = LINE_WORDS * XLEN;
  localparam int unsigned OFF_W     = $clog2(LINE_BITS / 8);
  localparam int unsigned IDX_W     = $clog2(SETS);
  localparam int unsigned TAG_W     = XLEN - OFF_W - IDX_W;
  localparam int unsigned WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {StIdle, StLookup, StWb, StFill} state_e;

  state_e                state_q;
  logic [XLEN-1:0]       addr_q;
  logic [XLEN-1:0]       wdata_q;
  logic                  we_q;
  logic [2:0]            size_q;
  logic [WAY_W-1:0]      victim_q;
  logic                  victim_inv_q;
  logic                  mem_we_q;
  logic [XLEN-1:0]       mem_addr_q;
  logic [LINE_BITS-1:0]  mem_wdata_q;

  logic                  valid_q [WAYS][SETS];
  logic                  dirty_q [WAYS][SETS];
  logic [WAY_W-1:0]      rr_q    [SETS];
  logic [TAG_W-1:0]      tag_q   [WAYS][SETS];
  logic [LINE_BITS-1:0]  data_q  [WAYS][SETS];

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  assign idx = addr_q[OFF_W +: IDX_W];
  assign tag = addr_q[XLEN-1 -: TAG_W];

  logic                  hit;
  logic [WAY_W-1:0]      hit_way;
  logic                  inv_found;
  logic [WAY_W-1:0]      inv_way;
  logic [WAY_W-1:0]      victim;
  logic [WAY_W-1:0]      rr_next;

  // Descending scan so the lowest-index match / invalid way wins.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[w][idx]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim  = inv_found ? inv_way : rr_q[idx];
    rr_next = (rr_q[idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;
  end

  logic [OFF_W-1:0]      boff;
  logic [OFF_W-1:0]      aoff;
  logic [31:0]           size_mask;
  logic [LINE_BITS-1:0]  hit_line;
  logic [31:0]           shifted;
  logic [LINE_BITS-1:0]  bmask;
  logic [LINE_BITS-1:0]  wsh;
  logic [LINE_BITS-1:0]  store_line;
  logic [XLEN-1:0]       load_val;

  // Byte lane alignment: halfwords drop addr[0], words drop addr[1:0].
  always_comb begin
    boff      = addr_q[OFF_W-1:0];
    aoff      = boff;
    size_mask = 32'hFFFF_FFFF;
    case (size_q[1:0])
      2'b00:   size_mask = 32'h0000_00FF;
      2'b01: begin
        aoff      = {boff[OFF_W-1:1], 1'b0};
        size_mask = 32'h0000_FFFF;
      end
      default: aoff = {boff[OFF_W-1:2], 2'b00};
    endcase
    hit_line   = data_q[hit_way][idx];
    shifted    = 32'(hit_line >> {aoff, 3'b000});
    bmask      = LINE_BITS'(size_mask) << {aoff, 3'b000};
    wsh        = LINE_BITS'(wdata_q[31:0]) << {aoff, 3'b000};
    store_line = (hit_line & ~bmask) | (wsh & bmask);
    case (size_q)
      3'b000:  load_val = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b100:  load_val = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b001:  load_val = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_val = XLEN'(shifted);
    endcase
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = (state_q == StLookup) && hit;
  assign bus.resp_rdata = (bus.resp_valid && !we_q) ? load_val : '0;
  assign bus.mem_req    = (state_q == StWb) || (state_q == StFill);
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

  // Line and tag storage carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if ((state_q == StLookup) && hit && we_q) begin
      data_q[hit_way][idx] <= store_line;
    end else if ((state_q == StFill) && bus.mem_ack) begin
      data_q[victim_q][idx] <= bus.mem_rdata;
      tag_q[victim_q][idx]  <= tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      size_q       <= '0;
      victim_q     <= '0;
      victim_inv_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < int'(WAYS); w++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
        end
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            state_q <= StLookup;
          end
        end
        StLookup: begin
          if (hit) begin
            if (we_q) dirty_q[hit_way][idx] <= 1'b1;
            state_q <= StIdle;
          end else begin
            victim_q     <= victim;
            victim_inv_q <= inv_found;
            if (valid_q[victim][idx] && dirty_q[victim][idx]) begin
              state_q     <= StWb;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {tag_q[victim][idx], idx, {OFF_W{1'b0}}};
              mem_wdata_q <= data_q[victim][idx];
            end else begin
              state_q    <= StFill;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {tag, idx, {OFF_W{1'b0}}};
            end
          end
        end
        StWb: begin
          if (bus.mem_ack) begin
            state_q    <= StFill;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {tag, idx, {OFF_W{1'b0}}};
          end
        end
        StFill: begin
          if (bus.mem_ack) begin
            valid_q[victim_q][idx] <= 1'b1;
            dirty_q[victim_q][idx] <= 1'b0;
            if (!victim_inv_q) rr_q[idx] <= rr_next;
            state_q <= StLookup;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic        replay_q;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // The LOOKUP right after a fill ack is the replay and is not counted as a hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      replay_q <= (state_q == StFill) && bus.mem_ack;
      if (state_q == StLookup) begin
        if (hit && !replay_q && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_q <= hit_cnt_q + 1'b1;
        if (!hit && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule

// File: doc/dcache_sa.md
DCACHE_SA -- requirements
Module: dcache_sa

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter WAYS, default 2, associativity (power of 2, >=1).
REQ-003 SHALL have parameter SETS, default 16, sets per way (power of 2, >=2).
REQ-004 SHALL have parameter LINE_WORDS, default 4, XLEN-bit words per line (power of 2, >=1).
REQ-005 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: req_valid  in  1  CPU request; req_ready  out  1  request accepted when both high.
REQ-007 SHALL have ports: req_addr  in  XLEN  byte address; req_we  in  1  store; req_size  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; req_wdata  in  XLEN  store data.
REQ-008 SHALL have ports: resp_valid  out  1  one-cycle completion pulse; resp_rdata  out  XLEN  load result (0 for stores).
REQ-009 SHALL have ports: mem_req  out  1; mem_we  out  1; mem_addr  out  XLEN  line-aligned; mem_wdata  out  LINE_WORDS*XLEN; mem_ack  in  1; mem_rdata  in  LINE_WORDS*XLEN.
REQ-010 SHALL have ports: hit_count  out  32; miss_count  out  32.

Function
REQ-011 Address split SHALL be offset = low log2(LINE_WORDS*XLEN/8) bits, index = next log2(SETS) bits, tag = remaining upper bits.
REQ-012 FSM states SHALL be IDLE, LOOKUP, WB, FILL; req_ready SHALL be 1 only in IDLE.
REQ-013 IDLE: on req_valid&&req_ready, the request SHALL be registered -> LOOKUP; otherwise stay.
REQ-014 LOOKUP hit (valid && tag match in any way): resp_valid=1 that cycle; loads return the selected bytes; stores update only the addressed bytes and set dirty; -> IDLE. Hit latency SHALL therefore be exactly 1 cycle after acceptance.
REQ-015 LOOKUP miss: victim = lowest-index invalid way, else the set's round-robin pointer; victim dirty -> WB, else -> FILL.
REQ-016 WB: mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wdata=victim line; on mem_ack -> FILL.
REQ-017 FILL: mem_req=1, mem_we=0, mem_addr=request line address; on mem_ack install mem_rdata, valid=1, dirty=0, new tag, advance set's round-robin pointer only if no invalid way was used; -> LOOKUP (replay, guaranteed hit).
REQ-018 mem_req, mem_we, mem_addr, mem_wdata SHALL remain stable from assertion until the mem_ack cycle; mem_req SHALL deassert the cycle after ack unless the next state issues a new transfer.
REQ-019 Loads: B/H SHALL sign-extend, BU/HU SHALL zero-extend, W unextended; halfword ignores addr[0], word ignores addr[1:0].
REQ-020 mem_ack outside WB/FILL SHALL be ignored.
REQ-021 Bytes within a line SHALL be little-endian; word k of a line SHALL occupy mem_rdata/mem_wdata bits [k*XLEN +: XLEN].

Reset
REQ-022 On rst, state SHALL become IDLE immediately; all valid/dirty bits and round-robin pointers SHALL clear; req_ready=1; resp_valid, mem_req, mem_we=0; resp_rdata, mem_addr, mem_wdata, hit_count, miss_count=0.
REQ-023 Reset during WB or FILL SHALL abandon the transfer; dirty data SHALL be lost; no response SHALL be produced.

Configuration
REQ-024 Macro DCACHE_STATS_EN defined: hit_count SHALL increment on each LOOKUP hit that is not a replay; miss_count SHALL increment on each LOOKUP miss; both saturate at 0xFFFFFFFF.
REQ-025 DCACHE_STATS_EN undefined: counters SHALL not be built; hit_count and miss_count SHALL be constant 0; ports SHALL remain.

Verification (defaults: index=addr[7:4], tag=addr[31:8])
REQ-026 After reset, LW 0x100 -> FILL mem_addr 0x100 (mem_we=0); ack with word0=0xDEADBEEF -> resp_rdata 0xDEADBEEF; then LW 0x104 -> resp_valid 1 cycle after accept, no mem_req.
REQ-027 SB 0x101 wdata 0x80 (line resident) -> LB 0x101 returns 0xFFFFFF80, LBU 0x101 returns 0x00000080, LW 0x100 shows byte1=0x80.
REQ-028 Stores to 0x100 and 0x200 (set 0, both ways dirty), then LW 0x300 -> WB mem_addr 0x100 with stored data, then FILL 0x300; next miss in set 0 evicts 0x200.
REQ-029 During FILL hold mem_ack low 10 cycles -> req_ready=0, mem_req/mem_addr unchanged all 10 cycles, single resp_valid after ack.
REQ-030 Assert rst mid-FILL -> mem_req=0 and req_ready=1 without a clock edge; later LW 0x100 misses again.
REQ-031 With DCACHE_STATS_EN: 2 cold misses then 3 hits -> miss_count=2, hit_count=3; without macro both read 0.
